// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives the datapath muxes and enables of a shared-ALU, shared-memory core.
module multicycle_controller #(
    parameter int unsigned ALUOP_W     = 4,
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic [1:0]         PCselect,
    output logic               IorD,
    output logic               ir_write,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               regWrite,
    output logic               RegDst,
    output logic               MemToReg,
    output logic               IsJal,
    output logic               IsLui,
    output logic               ALUsrcA,
    output logic [1:0]         ALUsrcB,
    output logic [ALUOP_W-1:0] ALUop,
    output logic               illegal,
    output logic [3:0]         state
);

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_JR       = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    state_t     cur_state;
    state_t     nxt_state;
    logic       mem_go;
    logic       op_lw;
    logic       op_sw;
    logic       op_rtype;
    logic       f_jr;
    logic       f_alu;
    logic       op_imm;
    logic       op_br;
    logic       op_j;
    logic [2:0] r_alu;
    logic [2:0] i_alu;

    // Memory phases advance on ready, or every cycle when waiting is disabled.
    assign mem_go   = mem_ready || (MEM_WAIT_EN == 0);

    assign op_lw    = (opcode == 6'd35);
    assign op_sw    = (opcode == 6'd43);
    assign op_rtype = (opcode == 6'd0);
    assign f_jr     = (func == 6'd8);
    assign f_alu    = func inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    assign op_imm   = opcode inside {6'd8, 6'd12, 6'd13, 6'd10, 6'd15};
    assign op_br    = opcode inside {6'd4, 6'd5};
    assign op_j     = opcode inside {6'd2, 6'd3};
    assign state    = cur_state;

    // ALU operation selected by R-type func field.
    always_comb begin
        r_alu = ALU_ADD;
        case (func)
            6'd34:   r_alu = ALU_SUB;
            6'd36:   r_alu = ALU_AND;
            6'd37:   r_alu = ALU_OR;
            6'd42:   r_alu = ALU_SLT;
            default: r_alu = ALU_ADD;
        endcase
    end

    // ALU operation selected by immediate opcode; lui falls through to ADD.
    always_comb begin
        i_alu = ALU_ADD;
        case (opcode)
            6'd12:   i_alu = ALU_AND;
            6'd13:   i_alu = ALU_OR;
            6'd10:   i_alu = ALU_SLT;
            default: i_alu = ALU_ADD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur_state <= S_FETCH;
        else      cur_state <= nxt_state;
    end

    // Next-state and datapath control decode.
    always_comb begin
        nxt_state = cur_state;
        pc_en     = 1'b0;
        PCselect  = 2'b00;
        IorD      = 1'b0;
        ir_write  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        regWrite  = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        IsJal     = 1'b0;
        IsLui     = 1'b0;
        ALUsrcA   = 1'b0;
        ALUsrcB   = 2'b00;
        ALUop     = ALUOP_W'(ALU_ADD);
        illegal   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUsrcB = 2'b01;
                if (mem_go) begin
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    nxt_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUsrcB = 2'b11;
                if (op_lw || op_sw)                      nxt_state = S_MEM_ADDR;
                else if (op_rtype && f_jr)               nxt_state = S_JR;
                else if ((op_rtype && f_alu) || op_imm)  nxt_state = S_EXEC;
                else if (op_br)                          nxt_state = S_BRANCH;
                else if (op_j)                           nxt_state = S_JUMP;
                else                                     nxt_state = S_ILLEGAL;
            end
            S_MEM_ADDR: begin
                ALUsrcA   = 1'b1;
                ALUsrcB   = 2'b10;
                nxt_state = op_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_go) nxt_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                regWrite  = 1'b1;
                MemToReg  = 1'b1;
                nxt_state = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_go) nxt_state = S_FETCH;
            end
            S_EXEC: begin
                ALUsrcA = 1'b1;
                if (op_rtype) begin
                    ALUsrcB = 2'b00;
                    ALUop   = ALUOP_W'(r_alu);
                end else begin
                    ALUsrcB = 2'b10;
                    ALUop   = ALUOP_W'(i_alu);
                end
                nxt_state = S_ALU_WB;
            end
            S_ALU_WB: begin
                regWrite  = 1'b1;
                RegDst    = op_rtype;
                IsLui     = (opcode == 6'd15);
                nxt_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUsrcA   = 1'b1;
                ALUop     = ALUOP_W'(ALU_SUB);
                PCselect  = 2'b01;
                pc_en     = (opcode == 6'd5) ? ~zero : zero;
                nxt_state = S_FETCH;
            end
            S_JUMP: begin
                pc_en    = 1'b1;
                PCselect = 2'b10;
                if (opcode == 6'd3) begin
                    regWrite = 1'b1;
                    IsJal    = 1'b1;
                end
                nxt_state = S_FETCH;
            end
            S_JR: begin
                pc_en     = 1'b1;
                PCselect  = 2'b11;
                nxt_state = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal   = 1'b1;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle MIPS control unit: FSM sequences fetch, decode, execute, memory and writeback over several clocks, driving a shared-ALU, shared-memory datapath.
- Successor to the single-cycle controller, adding:
  - parametrised ALU-op width;
  - a memory ready/stall handshake;
  - bne, jal and jr;
  - an illegal-instruction flag.
- Sits between the instruction register (opcode/func), ALU zero flag, memory ready and the datapath muxes/enables.

Parameters:
- ALUOP_W, 4, width of ALUop output (≥3).
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready=1; 0 = mem_ready ignored, every memory access takes one cycle.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous reset, active-low.
- opcode  in  6  IR[31:26].
- func  in  6  IR[5:0].
- zero  in  1  ALU zero flag, combinational from current-cycle ALU.
- mem_ready  in  1  memory access complete this cycle.
- pc_en  out  1  PC register load enable.
- PCselect  out  2  PC source: 00 ALU (PC+4), 01 branch target reg, 10 jump target, 11 rs (jr).
- IorD  out  1  memory address: 0 PC, 1 ALUOut.
- ir_write  out  1  IR load enable.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- regWrite  out  1  register-file write enable.
- RegDst  out  1  1 = rd, 0 = rt.
- MemToReg  out  1  1 = MDR, 0 = ALUOut.
- IsJal  out  1  write PC+4 to $31.
- IsLui  out  1  writeback value is imm<<16.
- ALUsrcA  out  1  0 PC, 1 rs.
- ALUsrcB  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- ALUop  out  ALUOP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT; zero-extended to width.
- illegal  out  1  one-cycle pulse on unsupported encoding.
- state  out  4  current state (debug).

Behaviour:
- Outputs are Moore-decoded from state, plus zero/mem_ready/opcode where noted. All outputs default 0 in every state except where listed.
- Reset (rst=0, any time, mid-access included):
  - state ← FETCH immediately;
  - all outputs are the FETCH-state values;
  - in-flight access abandoned, no regWrite or MemWrite issued.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, EXEC=6, ALU_WB=7, BRANCH=8, JUMP=9, JR=10, ILLEGAL=11.
- FETCH:
  - MemRead=1, IorD=0, ALUsrcA=0, ALUsrcB=01, ALUop=ADD.
  - When ready (mem_ready=1, or MEM_WAIT_EN=0): ir_write=1, pc_en=1, PCselect=00, → DECODE. Otherwise stay.
- DECODE:
  - ALUsrcA=0, ALUsrcB=11, ALUop=ADD (branch target latched by datapath).
  - Dispatch on opcode:
    - 35 (lw) / 43 (sw) → MEM_ADDR;
    - 0 with func 8 (jr) → JR;
    - 0 with func 32/34/36/37/42 → EXEC;
    - 8, 12, 13, 10, 15 (addi, andi, ori, slti, lui) → EXEC;
    - 4, 5 (beq, bne) → BRANCH;
    - 2, 3 (j, jal) → JUMP;
    - anything else → ILLEGAL.
- MEM_ADDR: ALUsrcA=1, ALUsrcB=10, ALUop=ADD; → MEM_RD if lw, else MEM_WR.
- MEM_RD: MemRead=1, IorD=1; ready → MEM_WB, else hold.
- MEM_WB: regWrite=1, RegDst=0, MemToReg=1; → FETCH.
- MEM_WR: MemWrite=1, IorD=1; ready → FETCH, else hold. MemWrite stays high while waiting.
- EXEC:
  - R-type: ALUsrcA=1, ALUsrcB=00, ALUop from func (32 ADD, 34 SUB, 36 AND, 37 OR, 42 SLT).
  - I-type: ALUsrcA=1, ALUsrcB=10, ALUop from opcode (8 ADD, 12 AND, 13 OR, 10 SLT).
  - lui: ALUop=ADD, value ignored.
  - → ALU_WB.
- ALU_WB:
  - regWrite=1, MemToReg=0;
  - RegDst=1 for R-type, 0 otherwise;
  - IsLui=1 for opcode 15;
  - → FETCH.
- BRANCH:
  - ALUsrcA=1, ALUsrcB=00, ALUop=SUB, PCselect=01;
  - pc_en = zero for beq, ~zero for bne, sampled this cycle;
  - → FETCH.
- JUMP:
  - pc_en=1, PCselect=10;
  - for jal: regWrite=1, IsJal=1;
  - → FETCH.
- JR: pc_en=1, PCselect=11; → FETCH.
- ILLEGAL: illegal=1 for exactly one cycle, no writes, PC already advanced; → FETCH.
- Latency with MEM_WAIT_EN=0:
  - R/I-type 4 cycles;
  - lw 5;
  - sw 4;
  - beq/bne/j/jal/jr 3;
  - illegal 3.
- Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds exactly one cycle.

Test Plan:
- rst=0 held 3 cycles, mid-MEM_WR: state=0, MemWrite=0 immediately (asynchronous); release → MemRead=1, IorD=0.
- MEM_WAIT_EN=0, opcode=0 func=32: state 0→1→6→7→0; in EXEC ALUop=0; in ALU_WB regWrite=1, RegDst=1.
- opcode=35, mem_ready low for 2 cycles in MEM_RD: states 0,1,2,3,3,3,4,0; regWrite=1, MemToReg=1 only in state 4.
- opcode=4, zero=0 → pc_en=0 in BRANCH; repeat with zero=1 → pc_en=1, PCselect=01; opcode=5 with zero=0 → pc_en=1.
- opcode=3: JUMP asserts pc_en=1, PCselect=10, regWrite=1, IsJal=1, then FETCH; opcode=0 func=8 → PCselect=11.
- opcode=0 func=16 and opcode=63: illegal=1 for one cycle only; regWrite=MemWrite=0 throughout; back to FETCH after 3 cycles.
